// File: rtl/svc_rv_dmem_resp_if.sv
// Core-side data-memory bus: read port, byte-strobed write port, and the freeze line.
// The core is the master; the responder drives rdata and stall back.
`timescale 1ns/1ps
interface svc_rv_dmem_resp_if;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        stall;

  modport master (output ren, raddr, we, waddr, wdata, wstrb, input rdata, stall);
  modport slave  (input ren, raddr, we, waddr, wdata, wstrb, output rdata, stall);
endinterface

// File: rtl/svc_rv_dmem_resp.sv
// BRAM-timed data memory for the svc_rv MEM stage: 1-cycle registered read.
// Each accept may be followed by up to MAX_STALL registered freeze cycles (fixed or LFSR).
`timescale 1ns/1ps
module svc_rv_dmem_resp #(
  parameter int          AW        = 10,
  parameter int          MAX_STALL = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         stall_mode,
  input  logic [1:0]         stall_len,
  svc_rv_dmem_resp_if.slave  dmem,
  output logic [15:0]        req_count,
  output logic [15:0]        stall_count
);

  localparam logic [1:0] MAX_N = 2'(MAX_STALL);

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [1:0]  n;
  logic [15:0] lfsr, lfsr_nxt;
  logic        accept;
  logic [AW-1:0] ridx, widx;
  logic [31:0] mem [0:(1<<AW)-1];
  logic        unused_addr_bits;

  function automatic logic [1:0] sat(input logic [1:0] v);
    return (v > MAX_N) ? MAX_N : v;
  endfunction

  assign ridx   = dmem.raddr[AW+1:2];
  assign widx   = dmem.waddr[AW+1:2];
  assign accept = (dmem.ren | dmem.we) && !dmem.stall;
  assign dmem.stall = (state == STALL);

  // Aliasing: upper address bits and the byte offset carry no meaning here.
  assign unused_addr_bits = ^{dmem.raddr[31:AW+2], dmem.raddr[1:0],
                              dmem.waddr[31:AW+2], dmem.waddr[1:0]};

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    n = 2'd0;
    case (stall_mode)
      2'd1:    n = sat(stall_len);
      2'd2:    n = sat(lfsr[1:0]);
      default: n = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && (n != 2'd0)) begin
          state_nxt = STALL;
          cnt_nxt   = n;
        end
      end
      STALL: begin
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      lfsr        <= LFSR_SEED;
      dmem.rdata  <= 32'h0;
      req_count   <= 16'h0;
      stall_count <= 16'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lfsr      <= lfsr_nxt;
        req_count <= req_count + 16'd1;
        if (dmem.ren) dmem.rdata <= mem[ridx];
      end
      if (dmem.stall) stall_count <= stall_count + 16'd1;
    end
  end

  // Contents are never reset; a write lands after the same-cycle read has sampled the old word.
  always_ff @(posedge clock) begin
    if (!reset && accept && dmem.we) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem.wstrb[b]) mem[widx][8*b +: 8] <= dmem.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_svc_rv_dmem_resp.sv
// Scoreboard bench for svc_rv_dmem_resp: driver queues expected read data, monitor checks rdata.
`timescale 1ns/1ps
module tb_svc_rv_dmem_resp;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  stall_mode;
  logic [1:0]  stall_len;
  logic [15:0] req_count;
  logic [15:0] stall_count;

  svc_rv_dmem_resp_if dmem();

  svc_rv_dmem_resp #(.AW(10), .MAX_STALL(2), .LFSR_SEED(16'hACE1)) dut (
    .clock       (clock),
    .reset       (reset),
    .stall_mode  (stall_mode),
    .stall_len   (stall_len),
    .dmem        (dmem),
    .req_count   (req_count),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic        rd_pend = 1'b0;
  int          exp_req = 0;
  int          exp_stalls = 0;
  logic [15:0] lfsr_ref = 16'hACE1;
  logic [31:0] shadow [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // rd_pend computed at one negedge means a read is accepted at the next posedge.
  always @(negedge clock) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata: unexpected read response %h, none queued", dmem.rdata);
      end else begin
        chk("rdata", dmem.rdata, exp_q.pop_front());
      end
    end
    rd_pend = !reset && dmem.ren && !dmem.stall;
  end

  task automatic idle();
    dmem.ren   = 1'b0;
    dmem.raddr = 32'h0;
    dmem.we    = 1'b0;
    dmem.waddr = 32'h0;
    dmem.wdata = 32'h0;
    dmem.wstrb = 4'h0;
  endtask

  // Called #1 after a posedge with the DUT expected to be ready; returns #1 after the accept edge.
  task automatic issue(input logic ren, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] exp_rd);
    dmem.ren   = ren;
    dmem.raddr = ra;
    dmem.we    = we;
    dmem.waddr = wa;
    dmem.wdata = wd;
    dmem.wstrb = ws;
    if (ren) exp_q.push_back(exp_rd);
    exp_req++;
    lfsr_ref = lfsr_step(lfsr_ref);
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    stall_mode = 2'd0;
    stall_len = 2'd0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rdata", dmem.rdata, 32'h0);
    chk("reset_stall", {31'h0, dmem.stall}, 32'h0);
    chk("reset_req_count", {16'h0, req_count}, 32'h0);
    chk("reset_stall_count", {16'h0, stall_count}, 32'h0);
    reset = 1'b0;

    // Mode 0: basic write/read
    issue(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    issue(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF);
    chk("m0_stall", {31'h0, dmem.stall}, 32'h0);
    chk("m0_req_count", {16'h0, req_count}, 32'd2);
    // Byte strobes
    issue(1'b0, 32'h0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0);
    issue(1'b0, 32'h0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0);
    issue(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0, 32'h11BB33DD);
    // Aliasing and read-before-write
    issue(1'b0, 32'h0, 1'b1, 32'h0, 32'h1, 4'hF, 32'h0);
    issue(1'b0, 32'h0, 1'b1, 32'h1000, 32'h2, 4'hF, 32'h0);
    issue(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2);
    issue(1'b1, 32'h0, 1'b1, 32'h0, 32'h5, 4'hF, 32'h2);
    issue(1'b1, 32'h3, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5);
    issue(1'b0, 32'h0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 32'h0);
    issue(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5);
    idle();
    chk("m0_req_count2", {16'h0, req_count}, 32'd12);
    chk("m0_stall_count", {16'h0, stall_count}, 32'h0);

    // Mode 1, stall_len saturates 3 -> 2; held/changed request must be ignored
    stall_mode = 2'd1;
    stall_len  = 2'd3;
    issue(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF);
    chk("m1_stall_t1", {31'h0, dmem.stall}, 32'h1);
    dmem.raddr = 32'h20;
    dmem.we = 1'b1; dmem.waddr = 32'h10; dmem.wdata = 32'h0; dmem.wstrb = 4'hF;
    stall_mode = 2'd0;
    @(posedge clock); #1;
    chk("m1_stall_t2", {31'h0, dmem.stall}, 32'h1);
    chk("m1_rdata_hold", dmem.rdata, 32'hDEADBEEF);
    @(posedge clock); #1;
    chk("m1_stall_t3", {31'h0, dmem.stall}, 32'h0);
    idle();
    exp_stalls = 2;
    chk("m1_stall_count", {16'h0, stall_count}, 32'd2);
    chk("m1_req_count", {16'h0, req_count}, 32'd13);
    issue(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF);
    stall_mode = 2'd1;
    stall_len  = 2'd1;
    issue(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0, 32'h11BB33DD);
    chk("m1_len1_t1", {31'h0, dmem.stall}, 32'h1);
    @(posedge clock); #1;
    chk("m1_len1_t2", {31'h0, dmem.stall}, 32'h0);
    idle();
    exp_stalls = 3;
    chk("m1_stall_count2", {16'h0, stall_count}, 32'd3);

    // Fill a 16-word window for the random phase
    stall_mode = 2'd0;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = $urandom;
      issue(1'b0, 32'h0, 1'b1, 32'(i << 2), shadow[i], 4'hF, 32'h0);
    end
    idle();

    // Mode 2: run length after each accept must equal min(lfsr[1:0],2) of the reference
    stall_mode = 2'd2;
    for (int i = 0; i < 1000; i++) begin
      logic [1:0]  rw;
      int          ri, wi, n, run;
      logic [31:0] wd, erd, ra;
      logic [3:0]  ws;
      rw  = 2'($urandom_range(1, 3));
      ri  = $urandom_range(0, 15);
      wi  = $urandom_range(0, 15);
      wd  = $urandom;
      ws  = 4'($urandom_range(0, 15));
      ra  = ($urandom & 32'hFFFF_F000) | 32'(ri << 2) | 32'($urandom_range(0, 3));
      erd = shadow[ri];
      n   = (lfsr_ref[1:0] > 2'd2) ? 2 : int'(lfsr_ref[1:0]);
      issue(rw[0], ra, rw[1], 32'(wi << 2) | 32'h0004_0000, wd, ws, erd);
      if (rw[1]) begin
        for (int b = 0; b < 4; b++) if (ws[b]) shadow[wi][8*b +: 8] = wd[8*b +: 8];
      end
      exp_stalls += n;
      run = 0;
      while (dmem.stall && run < 4) begin
        run++;
        @(posedge clock); #1;
      end
      chk("m2_stall_run", 32'(run), 32'(n));
    end
    idle();
    chk("m2_stall_count", {16'h0, stall_count}, 32'(exp_stalls[15:0]));
    chk("m2_req_count", {16'h0, req_count}, 32'(exp_req[15:0]));

    // Reset in the middle of a stall
    stall_mode = 2'd1;
    stall_len  = 2'd2;
    issue(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, shadow[4]);
    chk("rst_pre_stall", {31'h0, dmem.stall}, 32'h1);
    reset = 1'b1;
    idle();
    @(posedge clock); #1;
    chk("rst_stall", {31'h0, dmem.stall}, 32'h0);
    chk("rst_req_count", {16'h0, req_count}, 32'h0);
    chk("rst_stall_count", {16'h0, stall_count}, 32'h0);
    chk("rst_rdata", dmem.rdata, 32'h0);
    reset = 1'b0;
    exp_req = 0;
    lfsr_ref = 16'hACE1;
    stall_mode = 2'd0;
    issue(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, shadow[4]);
    idle();
    chk("post_rst_stall", {31'h0, dmem.stall}, 32'h0);
    chk("post_rst_req_count", {16'h0, req_count}, 32'd1);

    repeat (3) @(posedge clock);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
